// File: rtl/logic_unit_pipe_if.sv
// logic_unit_pipe_if: operand/result handshake bundle for logic_unit_pipe
//   slave  modport: unit side (takes operands, drives results/flags/count)
//   master modport: producer/consumer side
interface logic_unit_pipe_if #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2:0]         op;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   y;
  logic               zero;
  logic               parity;
  logic [COUNT_W-1:0] done_count;
  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, y, zero, parity, done_count
  );
  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, y, zero, parity, done_count
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered WIDTH-bit bitwise logic unit with 2-entry elastic buffer
//   clk, rst : clock, async active-high reset
//   io       : in_valid/in_ready/a/b/op in, out_valid/out_ready/y/zero/parity out, done_count
module logic_unit_pipe #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 8
) (
  input logic clk,
  input logic rst,
  logic_unit_pipe_if.slave io
);
  localparam int RW = WIDTH + 2;
  // stored beat layout: {parity, zero, y}; reset image is y=0, zero=1, parity=0
  localparam logic [RW-1:0] EMPTY = {1'b0, 1'b1, {WIDTH{1'b0}}};
  logic [WIDTH-1:0]   r;
  logic [RW-1:0]      res;
  logic [RW-1:0]      m_q, m_d, s_q, s_d;
  logic               m_full_q, m_full_d, s_full_q, s_full_d, rdy_q, rdy_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               in_x, out_x;
  always_comb begin
    r = io.op == 3'd0 ? ~io.a :
        io.op == 3'd1 ? io.a & io.b :
        io.op == 3'd2 ? io.a | io.b :
        io.op == 3'd3 ? io.a ^ io.b :
        io.op == 3'd4 ? ~(io.a & io.b) :
        io.op == 3'd5 ? ~(io.a | io.b) :
        io.op == 3'd6 ? ~(io.a ^ io.b) : io.a;
    res = {^r, ~|r, r};
  end
  always_comb begin
    in_x     = io.in_valid & io.in_ready;
    out_x    = m_full_q & io.out_ready;
    m_d      = m_q;
    s_d      = s_q;
    m_full_d = m_full_q;
    s_full_d = s_full_q;
    if (!m_full_q) begin
      m_full_d = in_x;
      m_d      = in_x ? res : m_q;
    end else if (out_x) begin
      // skid beat is older than any new beat, so it refills M first
      if (s_full_q) begin
        m_d      = s_q;
        s_full_d = 1'b0;
      end else if (in_x) m_d = res;
      else m_full_d = 1'b0;
    end else if (in_x) begin
      s_d      = res;
      s_full_d = 1'b1;
    end
    cnt_d = cnt_q + COUNT_W'(out_x);
    rdy_d = ~s_full_d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q      <= EMPTY;
      s_q      <= EMPTY;
      m_full_q <= 1'b0;
      s_full_q <= 1'b0;
      rdy_q    <= 1'b1;
      cnt_q    <= '0;
    end else begin
      m_q      <= m_d;
      s_q      <= s_d;
      m_full_q <= m_full_d;
      s_full_q <= s_full_d;
      rdy_q    <= rdy_d;
      cnt_q    <= cnt_d;
    end
  end
  // ready flop resets to 1 so the unit accepts immediately after release; gated low during reset
  assign io.in_ready   = rdy_q & ~rst;
  assign io.out_valid  = m_full_q;
  assign io.y          = m_q[WIDTH-1:0];
  assign io.zero       = m_q[WIDTH];
  assign io.parity     = m_q[WIDTH+1];
  assign io.done_count = cnt_q;
endmodule
